// File: rtl/sample_sequencer.sv
// Write-side sequencer for the receive FIFO: snapshots up to eight channel samples per strobe
// and writes them as one contiguous burst, prefixed by a tag word at the start of each gate window.
module sample_sequencer #(
  parameter int             DW       = 16,
  parameter int             LEVEL_W  = 12,
  parameter int             HEADROOM = 8,
  parameter logic [DW-1:0]  TAG_WORD = 16'h4000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               strobe,
  input  logic               gate_enable,
  input  logic [3:0]         channels,
  input  logic [DW-1:0]      din0,
  input  logic [DW-1:0]      din1,
  input  logic [DW-1:0]      din2,
  input  logic [DW-1:0]      din3,
  input  logic [DW-1:0]      din4,
  input  logic [DW-1:0]      din5,
  input  logic [DW-1:0]      din6,
  input  logic [DW-1:0]      din7,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               fifo_full,
  input  logic               clear_status,
  output logic               wr_req,
  output logic [DW-1:0]      wr_data,
  output logic               busy,
  output logic               overflow,
  output logic [7:0]         dropped_count
);

  typedef enum logic [1:0] {IDLE, TAG, WRITE} state_t;

  state_t            state, state_n;
  logic [2:0]        idx, idx_n, last_idx, last_idx_n;
  logic              tag_pending, tag_n;
  logic              wr_req_n, busy_n, ovf_n;
  logic [DW-1:0]     wr_data_n;
  logic [7:0]        cnt_n;
  logic [DW-1:0]     samples [8];
  logic [DW-1:0]     din_bus [8];
  logic [3:0]        n_eff, need;
  logic [LEVEL_W:0]  level_sum;
  logic              admit, load, emit, lost, drop;
  logic [DW-1:0]     word;
  logic [2:0]        idx_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign din_bus[0] = din0;
  assign din_bus[1] = din1;
  assign din_bus[2] = din2;
  assign din_bus[3] = din3;
  assign din_bus[4] = din4;
  assign din_bus[5] = din5;
  assign din_bus[6] = din6;
  assign din_bus[7] = din7;

  // Outputs are registered, so fifo_full seen at the edge that loads a word masks that word.
  assign n_eff     = (channels == 4'd0 || channels > 4'd8) ? 4'd8 : channels;
  assign need      = n_eff + {3'b000, tag_pending};
  assign level_sum = {1'b0, fifo_level} + (LEVEL_W+1)'(need) + (LEVEL_W+1)'(HEADROOM);
  assign admit     = !fifo_full && !level_sum[LEVEL_W];
  assign idx_inc   = idx + 3'd1;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    last_idx_n = last_idx;
    tag_n      = tag_pending;
    wr_req_n   = 1'b0;
    wr_data_n  = wr_data;
    busy_n     = busy;
    ovf_n      = overflow;
    cnt_n      = dropped_count;
    load       = 1'b0;
    emit       = 1'b0;
    lost       = 1'b0;
    drop       = 1'b0;
    word       = samples[0];

    if (clear_status) begin
      ovf_n = 1'b0;
      cnt_n = 8'd0;
    end
    if (!gate_enable) tag_n = 1'b1;

    case (state)
      IDLE: begin
        if (strobe && gate_enable) begin
          if (admit) begin
            load       = 1'b1;
            last_idx_n = 3'(n_eff - 4'd1);
            busy_n     = 1'b1;
            wr_req_n   = 1'b1;
            idx_n      = 3'd0;
            if (tag_pending) begin
              state_n   = TAG;
              wr_data_n = TAG_WORD;
              tag_n     = 1'b0;
            end else begin
              state_n   = WRITE;
              wr_data_n = din0;
            end
          end else begin
            drop = 1'b1;
          end
        end
      end
      TAG: begin
        state_n = WRITE;
        idx_n   = 3'd0;
        emit    = 1'b1;
        word    = samples[0];
      end
      WRITE: begin
        if (idx == last_idx) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          idx_n = idx_inc;
          emit  = 1'b1;
          word  = samples[idx_inc];
        end
      end
      default: state_n = IDLE;
    endcase

    if (emit) begin
      if (fifo_full) begin
        lost = 1'b1;
      end else begin
        wr_req_n  = 1'b1;
        wr_data_n = word;
      end
    end

    if (strobe && gate_enable && state != IDLE) drop = 1'b1;
    if (drop) begin
      ovf_n = 1'b1;
      cnt_n = sat_inc(cnt_n);
    end
    if (lost) ovf_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= 3'd0;
      last_idx      <= 3'd0;
      tag_pending   <= 1'b1;
      wr_req        <= 1'b0;
      wr_data       <= '0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      dropped_count <= 8'd0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      last_idx      <= last_idx_n;
      tag_pending   <= tag_n;
      wr_req        <= wr_req_n;
      wr_data       <= wr_data_n;
      busy          <= busy_n;
      overflow      <= ovf_n;
      dropped_count <= cnt_n;
    end
  end

  // Sample snapshot is pure data and is left out of reset.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++) samples[i] <= din_bus[i];
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: expected FIFO words are queued when a strobe is driven
// and compared in order as wr_req words appear; status and timing are checked inline.
module tb_sample_sequencer;
  localparam int DW = 16;
  localparam int LEVEL_W = 12;
  localparam logic [DW-1:0] TAG = 16'h4000;

  logic clk = 1'b0;
  logic reset, strobe, gate_enable, fifo_full, clear_status;
  logic [3:0] channels;
  logic [DW-1:0] din [8];
  logic [LEVEL_W-1:0] fifo_level;
  logic wr_req, busy, overflow;
  logic [DW-1:0] wr_data;
  logic [7:0] dropped_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  sample_sequencer dut (
    .clk(clk), .reset(reset), .strobe(strobe), .gate_enable(gate_enable),
    .channels(channels),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .din4(din[4]), .din5(din[5]), .din6(din[6]), .din7(din[7]),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .clear_status(clear_status),
    .wr_req(wr_req), .wr_data(wr_data), .busy(busy),
    .overflow(overflow), .dropped_count(dropped_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every written word must match the head of the expected queue.
  always @(negedge clk) begin
    if (wr_req === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_word: observed %0h expected none", wr_data);
      end
      if (exp_q.size() != 0) chk("wr_data", {16'h0, wr_data}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [DW-1:0] base, input int nch, input bit tag, input bit accept);
    strobe = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = base + DW'(i);
    if (accept) begin
      if (tag) exp_q.push_back(TAG);
      for (int i = 0; i < nch; i++) exp_q.push_back(base + DW'(i));
    end
    tick();
    strobe = 1'b0;
  endtask

  // Entered one step after the accepting edge; counts busy cycles of the burst.
  task automatic expect_burst(input string tag, input int need, input int drop_at, input int full_at);
    int cnt;
    chk({tag, "_first_wr_req"}, {31'h0, wr_req}, 32'h1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      cnt++;
      if (cnt == drop_at) begin
        strobe = 1'b1;
        for (int i = 0; i < 8; i++) din[i] = 16'hDEAD;
      end
      if (cnt == full_at) fifo_full = 1'b1;
      tick();
      strobe = 1'b0;
      fifo_full = 1'b0;
    end
    chk({tag, "_busy_len"}, cnt, need);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; strobe = 1'b0; gate_enable = 1'b0; fifo_full = 1'b0; clear_status = 1'b0;
    channels = 4'd4; fifo_level = '0;
    for (int i = 0; i < 8; i++) din[i] = '0;
    repeat (3) tick();
    chk("rst_wr_req", {31'h0, wr_req}, 32'h0);
    chk("rst_wr_data", {16'h0, wr_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_dropped", {24'h0, dropped_count}, 32'h0);
    reset = 1'b0;
    gate_enable = 1'b1;

    // First strobe of the window carries the tag; the next one does not.
    fire(16'h0001, 4, 1'b1, 1'b1);
    chk("tag_first_word", {16'h0, wr_data}, {16'h0, TAG});
    expect_burst("b4_tag", 5, 0, 0);
    repeat (4) tick();
    fire(16'h0001, 4, 1'b0, 1'b1);
    expect_burst("b4_notag", 4, 0, 0);

    // Gate reopen re-arms the tag; channels=0 means eight.
    gate_enable = 1'b0;
    tick();
    gate_enable = 1'b1;
    channels = 4'd0;
    fire(16'h0010, 8, 1'b1, 1'b1);
    expect_burst("b8_ch0", 9, 0, 0);

    // Admission boundaries around the 4095-word limit.
    gate_enable = 1'b0;
    tick();
    gate_enable = 1'b1;
    channels = 4'd8;
    fifo_level = 12'd4079;
    fire(16'h0020, 8, 1'b1, 1'b0);
    chk("rej_wr_req", {31'h0, wr_req}, 32'h0);
    chk("rej_busy", {31'h0, busy}, 32'h0);
    chk("rej_overflow", {31'h0, overflow}, 32'h1);
    chk("rej_dropped", {24'h0, dropped_count}, 32'h1);
    fifo_level = 12'd4078;
    fire(16'h0030, 8, 1'b1, 1'b1);
    expect_burst("acc_4078_tag", 9, 0, 0);
    fifo_level = 12'd4079;
    fire(16'h0040, 8, 1'b0, 1'b1);
    expect_burst("acc_4079_notag", 8, 0, 0);
    fifo_level = 12'd4080;
    fire(16'h0050, 8, 1'b0, 1'b0);
    chk("rej_4080_dropped", {24'h0, dropped_count}, 32'h2);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk("clr_overflow", {31'h0, overflow}, 32'h0);
    chk("clr_dropped", {24'h0, dropped_count}, 32'h0);

    // Strobe mid-burst is dropped without touching the snapshot; channels>8 means eight.
    fifo_level = '0;
    channels = 4'd12;
    fire(16'h0100, 8, 1'b0, 1'b1);
    expect_burst("midburst", 8, 3, 0);
    chk("midburst_dropped", {24'h0, dropped_count}, 32'h1);
    chk("midburst_overflow", {31'h0, overflow}, 32'h1);

    fifo_level = 12'd4095;
    strobe = 1'b1;
    repeat (300) tick();
    strobe = 1'b0;
    chk("sat_dropped", {24'h0, dropped_count}, 32'hFF);
    chk("sat_busy", {31'h0, busy}, 32'h0);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;

    // Full seen at the edge that loads idx 2 removes that word only.
    fifo_level = '0;
    channels = 4'd4;
    strobe = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = 16'h00A0 + DW'(i);
    exp_q.push_back(16'h00A0);
    exp_q.push_back(16'h00A1);
    exp_q.push_back(16'h00A3);
    tick();
    strobe = 1'b0;
    expect_burst("full_pulse", 4, 0, 2);
    chk("full_overflow", {31'h0, overflow}, 32'h1);
    chk("full_dropped", {24'h0, dropped_count}, 32'h0);

    // Clear coincident with a reject: the drop wins.
    fifo_level = 12'd4095;
    fire(16'h0060, 8, 1'b0, 1'b0);
    chk("pre_clr_dropped", {24'h0, dropped_count}, 32'h1);
    clear_status = 1'b1;
    fire(16'h0060, 8, 1'b0, 1'b0);
    clear_status = 1'b0;
    chk("clr_rej_overflow", {31'h0, overflow}, 32'h1);
    chk("clr_rej_dropped", {24'h0, dropped_count}, 32'h1);

    // Reset mid-burst aborts the burst and re-arms the tag.
    fifo_level = '0;
    channels = 4'd8;
    fire(16'h0300, 8, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_wr_req", {31'h0, wr_req}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_overflow", {31'h0, overflow}, 32'h0);
    exp_q.delete();
    reset = 1'b0;
    tick();
    channels = 4'd1;
    fire(16'h0055, 1, 1'b1, 1'b1);
    expect_burst("post_rst_ch1", 2, 0, 0);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
